// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table predictor: opcodes,
// resolve-type encodings, in-flight queue entry layout and a clog2 helper.
// Used by bht_predictor, bht_inflight_q and bht_predictor_if users.
package bht_pkg;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10
    } br_type_e;

    // Widest supported table index; the top uses only the low IDX_W bits.
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 pred;
    } q_entry_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch/resolve bus of the branch predictor.
// master: pipeline side driving fetch and resolve; slave: the predictor.
// Outputs pred_taken / pred_wrong are combinational on the slave side.
interface bht_predictor_if #(
    parameter int PC_W   = 32,
    parameter int QCNT_W = 2
);
    logic              stall;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [5:0]        if_opcode;
    logic              pred_taken;
    logic              res_valid;
    logic [1:0]        res_br_type;
    logic              res_equal;
    logic              pred_wrong;
    logic [QCNT_W-1:0] q_count;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output stall, if_valid, if_pc, if_opcode, res_valid, res_br_type, res_equal,
        input  pred_taken, pred_wrong, q_count, err_overflow, err_underflow
    );

    modport slave (
        input  stall, if_valid, if_pc, if_opcode, res_valid, res_br_type, res_equal,
        output pred_taken, pred_wrong, q_count, err_overflow, err_underflow
    );
endinterface

// File: rtl/bht_inflight_q.sv
// Circular queue of predicted branches awaiting resolution, with flush.
// Latency: head visible combinationally; push/pop/flush take effect next cycle.
// Backpressure: push while full without pop is dropped and sets sticky err_overflow.
module bht_inflight_q
    import bht_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req_i,
    input  logic                  pop_req_i,
    input  logic                  flush_i,
    input  q_entry_t              push_dat_i,
    output q_entry_t              head_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] count_o,
    output logic                  err_overflow_o,
    output logic                  err_underflow_o
);
    localparam int AW = clog2(DEPTH);

    q_entry_t      mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          full, push, pop;
    logic          ovf_q, unf_q;

    assign empty_o = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = pop_req_i & ~empty_o;
    assign push    = push_req_i & (~full | pop);
    assign wr_d    = wr_q + (AW+1)'(push);
    // A flush pops the head and then discards everything behind it.
    assign rd_d    = flush_i ? wr_d : rd_q + (AW+1)'(pop);

    assign head_o          = mem_q[rd_q[AW-1:0]];
    assign count_o         = wr_q - rd_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

    // Pointer and sticky error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_req_i & full & ~pop) ovf_q <= 1'b1;
            if (pop_req_i & empty_o)      unf_q <= 1'b1;
        end
    end

    // Entry storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table predictor: saturating counters indexed by fetch PC
// (XOR global history when BHT_GSHARE_EN is defined). Prediction is 0-cycle
// combinational; stall freezes all state; resolve trains, mispredict flushes.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int ENTRIES   = 16,
    parameter int CTR_W     = 2,
    parameter int CTR_RESET = 1,
    parameter int QDEPTH    = 2,
    parameter int HIST_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    bht_predictor_if.slave bus
);
    localparam int IDX_W  = clog2(ENTRIES);
    localparam int QCNT_W = clog2(QDEPTH) + 1;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_d;
    logic [IDX_W-1:0]  pc_idx, idx, head_idx;
    logic              is_br, pred_taken, resolve, actual, train, mispredict, push_req;
    q_entry_t          head, push_dat;
    logic              q_empty;
    logic [QCNT_W-1:0] q_count;
    logic              unused_bits;

    assign pc_idx = bus.if_pc[IDX_W+1:2];

`ifdef BHT_GSHARE_EN
    logic [HIST_W-1:0] hist_q, hist_d;

    assign idx    = pc_idx ^ IDX_W'(hist_q);
    assign hist_d = HIST_W'({hist_q, actual});

    // Global history shifts in the real outcome on every training event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        hist_q <= '0;
        else if (train) hist_q <= hist_d;
    end
`else
    logic unused_hist;
    assign idx         = pc_idx;
    assign unused_hist = (HIST_W > IDX_W);
`endif

    assign is_br      = bus.if_valid & ((bus.if_opcode == OP_BEQ) | (bus.if_opcode == OP_BNE));
    assign pred_taken = ~rst & is_br & ctr_q[idx][CTR_W-1];

    assign resolve    = bus.res_valid & ~bus.stall & (bus.res_br_type != BR_NONE);
    assign actual     = ((bus.res_br_type == BR_EQ) & bus.res_equal) |
                        ((bus.res_br_type == BR_NE) & ~bus.res_equal);
    assign train      = resolve & ~q_empty;
    assign head_idx   = head.idx[IDX_W-1:0];
    assign mispredict = ~rst & train & (head.pred != actual);
    // Fetches behind a mispredict are wrong-path and must not enter the queue.
    assign push_req   = is_br & ~bus.stall & ~mispredict;
    assign push_dat   = '{idx: IDX_MAX_W'(idx), pred: pred_taken};

    assign bus.pred_taken = pred_taken;
    assign bus.pred_wrong = mispredict;
    assign bus.q_count    = q_count;

    bht_inflight_q #(.DEPTH(QDEPTH)) u_q (
        .clk            (clk),
        .rst            (rst),
        .push_req_i     (push_req),
        .pop_req_i      (resolve),
        .flush_i        (mispredict),
        .push_dat_i     (push_dat),
        .head_o         (head),
        .empty_o        (q_empty),
        .count_o        (q_count),
        .err_overflow_o (bus.err_overflow),
        .err_underflow_o(bus.err_underflow)
    );

    // Saturating update of the counter the oldest branch was predicted from.
    always_comb begin
        ctr_d = ctr_q[head_idx];
        if (actual && ctr_d != CTR_MAX)       ctr_d = ctr_d + CTR_W'(1);
        else if (!actual && ctr_d != '0)      ctr_d = ctr_d - CTR_W'(1);
    end

    // Counter table: reset to CTR_RESET, written only on a training resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_W'(CTR_RESET);
        end else if (train) begin
            ctr_q[head_idx] <= ctr_d;
        end
    end

    generate
        if (IDX_W < IDX_MAX_W) begin : g_idx_hi
            assign unused_bits = ^{head.idx[IDX_MAX_W-1:IDX_W], bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0]};
        end else begin : g_idx_full
            assign unused_bits = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0]};
        end
    endgenerate

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed scenarios followed by random traffic,
// each cycle's expected outputs come from an abstract model and are queued
// for a negedge monitor to compare.
module tb_bht_predictor;
    localparam int PC_W      = 32;
    localparam int ENTRIES   = 16;
    localparam int CTR_W     = 2;
    localparam int CTR_RESET = 1;
    localparam int QDEPTH    = 2;
    localparam int HIST_W    = 4;
    localparam int QCNT_W    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bht_predictor_if #(.PC_W(PC_W), .QCNT_W(QCNT_W)) bus ();

    bht_predictor #(
        .PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CTR_RESET(CTR_RESET),
        .QDEPTH(QDEPTH), .HIST_W(HIST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int pt;
        int pw;
        int qc;
        int ovf;
        int unf;
    } exp_t;

    typedef struct {
        int idx;
        int pred;
    } ment_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model state
    int    m_ctr[ENTRIES];
    ment_t m_q[$];
    int    m_ovf, m_unf, m_hist;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CTR_RESET;
        m_q.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_hist = 0;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // One cycle: drive, predict the outputs, advance the model, wait an edge.
    task automatic cyc(input int r, input int s, input int v, input int pc,
                       input int op, input int rv, input int rt, input int re);
        exp_t e;
        int   idx, is_br, pt, res, act, pw;
        rst             = r[0];
        bus.stall       = s[0];
        bus.if_valid    = v[0];
        bus.if_pc       = PC_W'(pc);
        bus.if_opcode   = 6'(op);
        bus.res_valid   = rv[0];
        bus.res_br_type = 2'(rt);
        bus.res_equal   = re[0];
        if (r != 0) begin
            e = '{0, 0, 0, 0, 0};
            model_reset();
        end else begin
            idx = (pc >> 2) % ENTRIES;
`ifdef BHT_GSHARE_EN
            idx = idx ^ m_hist;
`endif
            is_br = (v != 0) && (op == 4 || op == 5);
            pt    = (is_br && m_ctr[idx] >= (1 << (CTR_W - 1))) ? 1 : 0;
            res   = (rv != 0) && (s == 0) && (rt != 0);
            act   = ((rt == 1 && re != 0) || (rt == 2 && re == 0)) ? 1 : 0;
            pw    = (res && m_q.size() > 0 && m_q[0].pred != act) ? 1 : 0;
            e     = '{pt, pw, m_q.size(), m_ovf, m_unf};
            if (res) begin
                if (m_q.size() > 0) begin
                    ment_t h;
                    h = m_q.pop_front();
                    if (act != 0) m_ctr[h.idx] = (m_ctr[h.idx] < (1 << CTR_W) - 1) ? m_ctr[h.idx] + 1 : m_ctr[h.idx];
                    else          m_ctr[h.idx] = (m_ctr[h.idx] > 0) ? m_ctr[h.idx] - 1 : 0;
                    m_hist = ((m_hist << 1) | act) % (1 << HIST_W);
                    if (pw != 0) m_q.delete();
                end else begin
                    m_unf = 1;
                end
            end
            if (is_br && s == 0 && pw == 0) begin
                if (m_q.size() < QDEPTH) m_q.push_back('{idx, pt});
                else m_ovf = 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented outputs with the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pred_taken",    int'(bus.pred_taken),    e.pt);
            check("pred_wrong",    int'(bus.pred_wrong),    e.pw);
            check("q_count",       int'(bus.q_count),       e.qc);
            check("err_overflow",  int'(bus.err_overflow),  e.ovf);
            check("err_underflow", int'(bus.err_underflow), e.unf);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r, s, v, pc, op, rv, rt, re;
        rst = 1'b1;
        bus.stall = 1'b0; bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_opcode = '0;
        bus.res_valid = 1'b0; bus.res_br_type = '0; bus.res_equal = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset, first prediction and first training
        cyc(1, 0, 0, 0,    0, 0, 0, 0);
        cyc(0, 0, 1, 'h40, 4, 0, 0, 0);
        cyc(0, 0, 0, 0,    0, 1, 1, 1);
        cyc(0, 0, 1, 'h40, 4, 0, 0, 0);
        // Saturate, then one not-taken
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 'h40, 4, 1, 1, 1);
        cyc(0, 0, 0, 0,    0, 1, 1, 0);
        cyc(0, 0, 1, 'h40, 4, 0, 0, 0);
        cyc(0, 0, 0, 0,    0, 1, 1, 1);
        // Ignored resolve type and underflow
        cyc(0, 0, 0, 0,    0, 1, 0, 1);
        cyc(0, 0, 0, 0,    0, 1, 2, 0);
        // Fill, overflow, push with simultaneous pop while full
        cyc(0, 0, 1, 'h80, 5, 0, 0, 0);
        cyc(0, 0, 1, 'h84, 5, 0, 0, 0);
        cyc(0, 0, 1, 'h88, 5, 0, 0, 0);
        cyc(0, 0, 1, 'h8c, 5, 1, 2, 1);
        cyc(0, 0, 0, 0,    0, 0, 0, 0);
        // Two in flight, first mispredicts with a same-cycle fetch branch
        cyc(0, 0, 0, 0,    0, 1, 2, 1);
        cyc(0, 0, 0, 0,    0, 1, 2, 1);
        cyc(0, 0, 1, 'h44, 4, 0, 0, 0);
        cyc(0, 0, 1, 'h48, 4, 0, 0, 0);
        cyc(0, 0, 1, 'h4c, 4, 1, 1, 1);
        cyc(0, 0, 1, 'h44, 4, 0, 0, 0);
        // Stall holds everything
        cyc(0, 1, 1, 'h44, 4, 1, 1, 1);
        cyc(0, 1, 1, 'h44, 4, 1, 1, 0);
        cyc(0, 0, 1, 'h44, 4, 0, 0, 0);
        // Reset mid-queue
        cyc(1, 0, 0, 0,    0, 0, 0, 0);
        cyc(0, 0, 1, 'h40, 4, 0, 0, 0);
        cyc(0, 0, 0, 0,    0, 1, 1, 0);
        // History pattern T,T,N,T then a fetch from pc 0
        cyc(0, 0, 1, 'h100, 4, 0, 0, 0);
        cyc(0, 0, 1, 'h104, 4, 1, 1, 1);
        cyc(0, 0, 1, 'h108, 4, 1, 1, 1);
        cyc(0, 0, 1, 'h10c, 4, 1, 1, 0);
        cyc(0, 0, 0, 0,     0, 1, 1, 1);
        cyc(0, 0, 1, 'h0,   4, 0, 0, 0);
        cyc(0, 0, 0, 0,     0, 1, 1, 1);
        cyc(0, 0, 1, 'h0,   4, 0, 0, 0);
        cyc(0, 0, 0, 0,     0, 1, 1, 1);

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            r  = ($urandom_range(0, 199) == 0) ? 1 : 0;
            s  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            v  = $urandom_range(0, 3) != 0 ? 1 : 0;
            pc = int'($urandom_range(0, 1023));
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(4, 5));
            rv = $urandom_range(0, 1);
            rt = $urandom_range(0, 3);
            re = $urandom_range(0, 1);
            cyc(r, s, v, pc, op, rv, rt, re);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
